// File: rtl/accum_sequencer.sv
// accum_sequencer: control sequencer for a multiply-accumulate datapath.
//
// Walks taps within a channel and channels within a sequence. Each accepted
// product beat advances the tap counter. After the last tap of a channel the
// completed sum is presented downstream (out_valid) until taken (out_ready).
// After the last channel the block returns to idle and pulses done for one cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a sequence (sampled only in idle)
//   cfg_taps   taps per channel   (0 treated as 1, latched on start)
//   cfg_chans  channels per sequence (0 treated as 1, latched on start)
//   in_valid   upstream product beat valid
//   in_ready   sequencer accepts a beat
//   acc_en     accumulate this beat (in_valid & in_ready)
//   acc_clr    load the accumulator instead of adding (first tap of a channel)
//   tap_idx    current tap index
//   ch_idx     current channel index
//   out_valid  channel sum complete and held for downstream
//   out_ready  downstream takes the sum
//   out_ch     channel number of the presented sum
//   busy       any state other than idle
//   done       one-cycle pulse after the final output handshake
module accum_sequencer #(
    parameter int unsigned TAP_W = 4,
    parameter int unsigned CH_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TAP_W-1:0] cfg_taps,
    input  logic [CH_W-1:0]  cfg_chans,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_en,
    output logic             acc_clr,
    output logic [TAP_W-1:0] tap_idx,
    output logic [CH_W-1:0]  ch_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic             busy,
    output logic             done
);

    localparam logic [TAP_W-1:0] TapOne = TAP_W'(1);
    localparam logic [CH_W-1:0]  ChOne  = CH_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [TAP_W-1:0] taps_q, taps_d;
    logic [CH_W-1:0]  chans_q, chans_d;
    logic             done_q, done_d;

    // Handshake outputs depend only on state, so acc_en has no path from out_ready.
    always_comb begin
        in_ready  = (state_q == StRun);
        out_valid = (state_q == StFlush);
        busy      = (state_q != StIdle);
        acc_en    = in_valid & in_ready;
        acc_clr   = acc_en & (tap_q == '0);
        tap_idx   = tap_q;
        ch_idx    = ch_q;
        out_ch    = ch_q;
        done      = done_q;
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        ch_d    = ch_q;
        taps_d  = taps_q;
        chans_d = chans_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // A zero bound would make the last-index compare underflow.
                    taps_d  = (cfg_taps == '0) ? TapOne : cfg_taps;
                    chans_d = (cfg_chans == '0) ? ChOne : cfg_chans;
                    tap_d   = '0;
                    ch_d    = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (acc_en) begin
                    if (tap_q == taps_q - TapOne) begin
                        tap_d   = '0;
                        state_d = StFlush;
                    end else begin
                        tap_d = tap_q + TapOne;
                    end
                end
            end
            StFlush: begin
                if (out_ready) begin
                    if (ch_q == chans_q - ChOne) begin
                        ch_d    = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ch_d    = ch_q + ChOne;
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tap_d   = '0;
                ch_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tap_q   <= '0;
            ch_q    <= '0;
            taps_q  <= TapOne;
            chans_q <= ChOne;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            ch_q    <= ch_d;
            taps_q  <= taps_d;
            chans_q <= chans_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_accum_sequencer.sv
// Self-checking bench for accum_sequencer: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// counting model of the sequence (beats per channel, channels per sequence).
module tb_accum_sequencer;

    localparam int TAP_W = 4;
    localparam int CH_W  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [TAP_W-1:0] cfg_taps = '0;
    logic [CH_W-1:0]  cfg_chans = '0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready, acc_en, acc_clr, out_valid, busy, done;
    logic [TAP_W-1:0] tap_idx;
    logic [CH_W-1:0]  ch_idx, out_ch;

    accum_sequencer #(.TAP_W(TAP_W), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_taps  (cfg_taps),
        .cfg_chans (cfg_chans),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .tap_idx   (tap_idx),
        .ch_idx    (ch_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: progress through the sequence as plain counts.
    bit m_known = 1'b0;
    bit m_busy, m_flush, m_done;
    int m_tap, m_ch, m_taps, m_chans;

    // Observation counters for the directed scenarios.
    int cyc = 0;
    int n_acc_en, n_acc_clr, n_ouths, n_done, n_bp;
    int first_acc_cyc, last_acc_cyc, clr_cyc, first_ov_cyc, hs_cyc, done_cyc;
    int out_chs[16];

    task automatic clear_counters();
        n_acc_en = 0; n_acc_clr = 0; n_ouths = 0; n_done = 0; n_bp = 0;
        first_acc_cyc = -1; last_acc_cyc = -1; clr_cyc = -1;
        first_ov_cyc = -1; hs_cyc = -1; done_cyc = -1;
        for (int i = 0; i < 16; i++) out_chs[i] = -1;
    endtask

    // Single compare/model process: inputs are stable between this edge and the next rising edge.
    always @(negedge clk) begin
        logic e_in_ready, e_acc_en;
        cyc++;
        if (m_known) begin
            e_in_ready = m_busy && !m_flush;
            e_acc_en   = in_valid && e_in_ready;
            check("in_ready",  32'(in_ready),  32'(e_in_ready));
            check("acc_en",    32'(acc_en),    32'(e_acc_en));
            check("acc_clr",   32'(acc_clr),   32'(e_acc_en && m_tap == 0));
            check("out_valid", 32'(out_valid), 32'(m_flush));
            check("busy",      32'(busy),      32'(m_busy));
            check("done",      32'(done),      32'(m_done));
            check("tap_idx",   32'(tap_idx),   32'(m_tap));
            check("ch_idx",    32'(ch_idx),    32'(m_ch));
            check("out_ch",    32'(out_ch),    32'(m_ch));
        end

        if (acc_en === 1'b1) begin
            if (n_acc_en == 0) first_acc_cyc = cyc;
            n_acc_en++;
            last_acc_cyc = cyc;
        end
        if (acc_clr === 1'b1) begin
            n_acc_clr++;
            clr_cyc = cyc;
        end
        if (out_valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (out_valid === 1'b1 && out_ready) begin
            if (n_ouths < 16) out_chs[n_ouths] = int'(out_ch);
            n_ouths++;
            hs_cyc = cyc;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (out_valid === 1'b1 && !out_ready && in_valid && in_ready === 1'b0 &&
            acc_en === 1'b0 && out_ch === '0) n_bp++;

        if (rst) begin
            m_known = 1'b1;
            m_busy = 0; m_flush = 0; m_done = 0;
            m_tap = 0; m_ch = 0; m_taps = 1; m_chans = 1;
        end else if (m_known) begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_taps  = (cfg_taps == 0) ? 1 : int'(cfg_taps);
                    m_chans = (cfg_chans == 0) ? 1 : int'(cfg_chans);
                    m_tap = 0; m_ch = 0;
                    m_busy = 1; m_flush = 0;
                end
            end else if (!m_flush) begin
                if (in_valid) begin
                    m_tap++;
                    if (m_tap == m_taps) begin
                        m_tap = 0;
                        m_flush = 1;
                    end
                end
            end else if (out_ready) begin
                m_ch++;
                m_flush = 0;
                if (m_ch == m_chans) begin
                    m_ch = 0;
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle number on which start was presented.
    task automatic do_start(input int taps, input int chans, output int s_cyc);
        start = 1'b1;
        cfg_taps = TAP_W'(taps);
        cfg_chans = CH_W'(chans);
        step();
        s_cyc = cyc;
        start = 1'b0;
        // Scramble config after the handshake; it must have no effect.
        cfg_taps = TAP_W'($urandom_range(0, 15));
        cfg_chans = CH_W'($urandom_range(0, 15));
    endtask

    // iv_mode: 0 always valid, 1 toggle 1/0, 2 random. or_mode: 0 always ready, 2 random.
    task automatic run_seq(input int iv_mode, input int or_mode, input int max_cyc);
        int d0 = n_done;
        int k = 0;
        bit tog = 1'b1;
        while (n_done == d0 && k < max_cyc) begin
            case (iv_mode)
                0: in_valid = 1'b1;
                1: begin in_valid = tog; tog = !tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            out_ready = (or_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            k++;
        end
        if (n_done == d0) check("seq_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int s;
        clear_counters();
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(0));
        check("reset_out_valid", 32'(out_valid), 32'(0));

        // 3x3 kernel, single channel, back-to-back beats.
        clear_counters();
        do_start(9, 1, s);
        run_seq(0, 0, 200);
        check("k9_acc_en", 32'(n_acc_en), 32'(9));
        check("k9_acc_clr", 32'(n_acc_clr), 32'(1));
        check("k9_clr_beat0", 32'(clr_cyc - s), 32'(1));
        check("k9_first_beat", 32'(first_acc_cyc - s), 32'(1));
        check("k9_last_beat", 32'(last_acc_cyc - s), 32'(9));
        check("k9_out_valid", 32'(first_ov_cyc - s), 32'(10));
        check("k9_done", 32'(done_cyc - s), 32'(11));

        // Multi-channel with gaps.
        clear_counters();
        do_start(3, 4, s);
        run_seq(1, 0, 500);
        check("mc_acc_en", 32'(n_acc_en), 32'(12));
        check("mc_ouths", 32'(n_ouths), 32'(4));
        for (int i = 0; i < 4; i++) check("mc_out_ch", 32'(out_chs[i]), 32'(i));
        check("mc_done", 32'(n_done), 32'(1));

        // Backpressure in flush.
        clear_counters();
        do_start(2, 2, s);
        in_valid = 1'b1;
        out_ready = 1'b0;
        repeat (7) step();
        check("bp_held_cycles", 32'(n_bp), 32'(5));
        check("bp_out_valid", 32'(out_valid), 32'(1));
        check("bp_in_ready", 32'(in_ready), 32'(0));
        check("bp_acc_en", 32'(n_acc_en), 32'(2));
        run_seq(0, 0, 200);
        check("bp_total_beats", 32'(n_acc_en), 32'(4));
        check("bp_ouths", 32'(n_ouths), 32'(2));

        // Zero configuration behaves as 1x1.
        clear_counters();
        do_start(0, 0, s);
        run_seq(0, 0, 50);
        check("z_acc_en", 32'(n_acc_en), 32'(1));
        check("z_acc_clr", 32'(n_acc_clr), 32'(1));
        check("z_ouths", 32'(n_ouths), 32'(1));
        check("z_done_cyc", 32'(done_cyc - s), 32'(3));

        // Reset mid-run after beat 4 of 9.
        clear_counters();
        do_start(9, 1, s);
        in_valid = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_busy", 32'(busy), 32'(0));
        check("mr_tap_idx", 32'(tap_idx), 32'(0));
        check("mr_in_ready", 32'(in_ready), 32'(0));
        step();
        check("mr_no_done", 32'(n_done), 32'(0));
        check("mr_beats", 32'(n_acc_en), 32'(5));
        clear_counters();
        do_start(9, 1, s);
        run_seq(0, 0, 200);
        check("mr_rerun_beats", 32'(n_acc_en), 32'(9));
        check("mr_rerun_done", 32'(done_cyc - s), 32'(11));

        // Start held high across a sequence and its done cycle.
        clear_counters();
        start = 1'b1;
        cfg_taps = TAP_W'(2);
        cfg_chans = CH_W'(2);
        step();
        run_seq(0, 0, 200);
        check("sc_restarted", 32'(busy), 32'(1));
        check("sc_first_beats", 32'(n_acc_en), 32'(4));
        start = 1'b0;
        clear_counters();
        run_seq(0, 0, 200);
        check("sc_second_beats", 32'(n_acc_en), 32'(4));
        check("sc_second_done", 32'(n_done), 32'(1));

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            cfg_taps = TAP_W'($urandom_range(0, 15));
            cfg_chans = CH_W'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst = 1'b0;
        start = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
